morse_msg_scheduler: RTL
========================

MORSE_MSG_SCHEDULER -- requirements
Module: morse_msg_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, clocks per Morse time unit (0.5 s at 50 MHz).
REQ-002 SHALL have parameter DEPTH, default 8, letter-queue capacity (power of two).
REQ-003 SHALL have port CLOCK_50  in  1  system clock; the block has one clock, and all logic is rising-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port push  in  1  enqueue `letter` this cycle.
REQ-006 SHALL have port letter  in  3  letter code 0..7 = A..H.
REQ-007 SHALL have port start  in  1  begin playback of queue contents.
REQ-008 SHALL have port abort  in  1  stop playback and flush queue.
REQ-009 SHALL have port full  out  1  queue holds DEPTH letters.
REQ-010 SHALL have port empty  out  1  queue holds 0 letters.
REQ-011 SHALL have port count  out  $clog2(DEPTH)+1  number of queued letters.
REQ-012 SHALL have port busy  out  1  playback in progress (state not IDLE).
REQ-013 SHALL have port led  out  1  Morse output, 1 = tone on.
REQ-014 SHALL have port done  out  1  one-cycle pulse at the natural end of a message.
REQ-015 SHALL have port cur_letter  out  3  code of the letter being sent, or last sent.

Function
REQ-016 Encoding SHALL be MSB-first, 1 = dash: A .- (len 2), B -... (4), C -.-. (4), D -.. (3), E . (1), F ..-. (4), G --. (3), H .... (4).
REQ-017 Timing SHALL be in ticks: dot = 1 tick on, dash = 3 ticks on, intra-letter gap = 1 tick off, inter-letter gap = 3 ticks off; 1 tick = TICK_DIV clocks.
REQ-018 The prescaler SHALL be cleared on every state entry, so that each on/off interval lasts exactly N×TICK_DIV clocks.
REQ-019 The FSM SHALL have states IDLE, LOAD, ON, GAP, LGAP and DONE.
REQ-020 In IDLE, start with empty=0 SHALL move the FSM to LOAD on the next cycle; start with empty=1 SHALL be ignored.
REQ-021 LOAD SHALL last 1 clock: it pops the head letter, loads the pattern into a shift register and the length into an element counter, updates cur_letter, and then goes to ON.
REQ-022 ON SHALL drive led=1 for 1 or 3 ticks according to the pattern MSB, then shift the pattern left and decrement the element counter.
REQ-023 After ON, the FSM SHALL go to GAP if elements remain, else to LGAP if the queue is non-empty, else to DONE.
REQ-024 After GAP the FSM SHALL go to ON; after LGAP it SHALL go to LOAD.
REQ-025 DONE SHALL last 1 clock with done=1, then return to IDLE.
REQ-026 led SHALL be 1 only in ON; done SHALL be 1 only in DONE.
REQ-027 push while full SHALL be dropped, with count unchanged.
REQ-028 push SHALL be accepted in any state, including while busy.
REQ-029 A simultaneous push and LOAD pop SHALL leave count unchanged.
REQ-030 The queue pointers SHALL wrap modulo DEPTH.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort SHALL take priority over push and start: the next state is IDLE, led=0, the queue is flushed (count=0), and no done pulse is produced.

Reset
REQ-033 Reset SHALL set the state to IDLE, clear the pointers and count, and clear the prescaler, shift register and element counter.
REQ-034 Reset SHALL drive outputs to led=0, done=0, busy=0, full=0, empty=1, count=0, cur_letter=0.
REQ-035 Reset asserted mid-message SHALL behave as abort, immediately and asynchronously.

Structure
REQ-036 A shared package morse_pkg SHALL hold the state enum, the letter-code constants A..H, and the pattern/length table type.
REQ-037 A single sub-module morse_rom SHALL map letter (3) to pattern (4) and length (3), combinationally.
REQ-038 The queue, prescaler and FSM SHALL remain in morse_msg_scheduler.

Verification (TICK_DIV=4, DEPTH=8)
REQ-039 Push E, then start: led=1 for exactly 4 clocks, then LGAP is skipped, then done pulses for 1 clock and busy=0.
REQ-040 Push A, then start: led 4 clocks on, 4 off, 12 on, then done; cur_letter=0.
REQ-041 Push A, push E, then start: A's pattern, then 12 clocks off, then 4 clocks on, then done; count goes 2, 1, 0.
REQ-042 Push 9 letters while idle: full=1 after the 8th, the 9th is dropped, count=8, and playback sends exactly 8 letters.
REQ-043 Queue B, start, and assert abort in the middle of the first dash: led=0 on the next clock, empty=1, no done pulse.
REQ-044 Push C during D's playback: C plays after a 12-clock inter-letter gap.
REQ-045 Assert reset during ON: led=0 and busy=0 asynchronously, and count=0.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse message scheduler.
// Letter codes, FSM state encoding and the pattern/length table entry.
package morse_pkg;

  localparam int unsigned LTR_W = 3;
  localparam int unsigned PAT_W = 4;
  localparam int unsigned LEN_W = 3;

  localparam logic [LTR_W-1:0] LTR_A = 3'd0;
  localparam logic [LTR_W-1:0] LTR_B = 3'd1;
  localparam logic [LTR_W-1:0] LTR_C = 3'd2;
  localparam logic [LTR_W-1:0] LTR_D = 3'd3;
  localparam logic [LTR_W-1:0] LTR_E = 3'd4;
  localparam logic [LTR_W-1:0] LTR_F = 3'd5;
  localparam logic [LTR_W-1:0] LTR_G = 3'd6;
  localparam logic [LTR_W-1:0] LTR_H = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ON   = 3'd2,
    GAP  = 3'd3,
    LGAP = 3'd4,
    DONE = 3'd5
  } state_t;

  // Pattern is MSB-first, 1 = dash; only the top len bits are meaningful.
  typedef struct packed {
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
  } morse_code_t;

endpackage

// File: rtl/morse_rom.sv
// Combinational letter-to-Morse lookup for letters A..H.
module morse_rom
  import morse_pkg::*;
(
  input  logic [2:0] letter,
  output logic [3:0] pattern,
  output logic [2:0] len
);

  morse_code_t code;

  always_comb begin
    code = '0;
    case (letter)
      LTR_A:   code = '{pattern: 4'b0100, len: 3'd2};
      LTR_B:   code = '{pattern: 4'b1000, len: 3'd4};
      LTR_C:   code = '{pattern: 4'b1010, len: 3'd4};
      LTR_D:   code = '{pattern: 4'b1000, len: 3'd3};
      LTR_E:   code = '{pattern: 4'b0000, len: 3'd1};
      LTR_F:   code = '{pattern: 4'b0010, len: 3'd4};
      LTR_G:   code = '{pattern: 4'b1100, len: 3'd3};
      LTR_H:   code = '{pattern: 4'b0000, len: 3'd4};
      default: code = '0;
    endcase
  end

  assign pattern = code.pattern;
  assign len     = code.len;

endmodule

// File: rtl/morse_msg_scheduler.sv
// Queues letters A..H and plays them back as Morse on an LED.
// One prescaler tick is TICK_DIV clocks; every interval restarts the prescaler.
module morse_msg_scheduler
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   push,
  input  logic [2:0]             letter,
  input  logic                   start,
  input  logic                   abort,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   led,
  output logic                   done,
  output logic [2:0]             cur_letter
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t state, state_nxt;

  logic [2:0]    queue_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic          push_ok, pop;

  logic [PW-1:0] presc;
  logic [1:0]    ticks, ticks_need;
  logic          tick_end, interval_end;

  logic [3:0]    shreg;
  logic [2:0]    elems;
  logic [2:0]    head_ltr;
  logic [3:0]    rom_pattern;
  logic [2:0]    rom_len;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign head_ltr = queue_mem[rd_ptr];
  assign push_ok  = push && !abort && (count != CW'(DEPTH));
  assign pop      = (state == LOAD) && !abort;

  morse_rom u_rom (
    .letter  (head_ltr),
    .pattern (rom_pattern),
    .len     (rom_len)
  );

  // Letter storage; contents need no reset since pointers gate all reads.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) queue_mem[wr_ptr] <= letter;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_comb begin
    cnt_nxt = count;
    if (abort)                cnt_nxt = '0;
    else if (push_ok && !pop) cnt_nxt = count + CW'(1);
    else if (!push_ok && pop) cnt_nxt = count - CW'(1);
  end

  // Interval length in ticks minus one: dash and inter-letter gap are 3, the rest 1.
  always_comb begin
    ticks_need = 2'd0;
    if ((state == ON && shreg[3]) || state == LGAP) ticks_need = 2'd2;
  end

  assign tick_end     = (presc == PW'(TICK_DIV - 1));
  assign interval_end = tick_end && (ticks == ticks_need);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && count != '0) state_nxt = LOAD;
      LOAD: state_nxt = ON;
      ON: begin
        if (interval_end) begin
          if (elems > 3'd1)         state_nxt = GAP;
          else if (count != '0)     state_nxt = LGAP;
          else                      state_nxt = DONE;
        end
      end
      GAP:  if (interval_end) state_nxt = ON;
      LGAP: if (interval_end) state_nxt = LOAD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Prescaler restarts on every state change so each interval is whole ticks.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      presc <= '0;
      ticks <= '0;
    end else if (state_nxt != state) begin
      presc <= '0;
      ticks <= '0;
    end else if (state inside {ON, GAP, LGAP}) begin
      if (tick_end) begin
        presc <= '0;
        ticks <= ticks + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      elems      <= '0;
      cur_letter <= '0;
    end else if (state == LOAD) begin
      shreg      <= rom_pattern;
      elems      <= rom_len;
      cur_letter <= head_ltr;
    end else if (state == ON && interval_end) begin
      shreg <= {shreg[2:0], 1'b0};
      elems <= elems - 3'd1;
    end
  end

  // Status outputs registered from next-state values so they track the state exactly.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      led   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      full  <= 1'b0;
      empty <= 1'b1;
      count <= '0;
    end else begin
      led   <= (state_nxt == ON);
      done  <= (state_nxt == DONE);
      busy  <= (state_nxt != IDLE);
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
      count <= cnt_nxt;
    end
  end

endmodule
